bp_cce_lite: RTL and testbench
==============================

Name: bp_cce_lite

Overview:
- Minimal single-transaction Cache Coherence Engine (CCE) that terminates the LCE-side protocol: accepts LCE requests, drives memory, and returns LCE commands.
- Used in single-core or bring-up configurations where no directory or sharer tracking is required.
- Completes the LCE sync handshake after reset, then services one request at a time end to end: request, memory, command, then ack.

Parameters:
- bp_params_p, e_bp_default_cfg, processor configuration; provides paddr_width_p, lce_id_width_p, cce_id_width_p, cce_block_width_p, lce_assoc_p and the bedrock message widths.
- num_lce_p, 1, number of LCEs that must be synced after reset (1..16).
- cce_id_p, 0, value placed in the src/cce_id field of every outgoing command.

Ports:
- clk_i in 1 clock.
- reset_n_i in 1 asynchronous active-low reset.
- lce_req_i in lce_req_msg_width_lp LCE request (type rd/wr/uc_rd/uc_wr, addr, src lce_id, lru_way, size, uc data).
- lce_req_v_i in 1 request valid.
- lce_req_ready_o out 1 ready; request accepted when ready&valid.
- lce_cmd_o out lce_cmd_msg_width_lp LCE command (sync, data fill with tag/way/state, uc_data, uc_st_done).
- lce_cmd_v_o out 1 command valid.
- lce_cmd_yumi_i in 1 command consumed.
- lce_resp_i in lce_resp_msg_width_lp LCE response (sync_ack, coh_ack).
- lce_resp_v_i in 1 response valid.
- lce_resp_ready_o out 1 response ready.
- mem_cmd_o out mem_msg_width_lp memory command (rd block, uc_rd, uc_wr).
- mem_cmd_v_o out 1 memory command valid.
- mem_cmd_ready_i in 1 memory ready.
- mem_resp_i in mem_msg_width_lp memory response with data.
- mem_resp_v_i in 1 memory response valid.
- mem_resp_yumi_o out 1 memory response consumed.
- busy_o out 1 high in every state except e_ready.

Behaviour:
- Reset: asynchronous, effective immediately on reset_n_i low.
  - FSM goes to e_sync_send; sync_cnt=0; all registers cleared.
  - All valid, ready and yumi outputs are 0; busy_o is 1.
  - A transaction in flight when reset asserts is dropped, with no partial output.
- e_sync_send:
  - lce_cmd_v_o=1 with type sync, dst=sync_cnt.
  - On yumi, go to e_sync_ack.
- e_sync_ack:
  - lce_resp_ready_o=1.
  - On a valid response of type sync_ack with src==sync_cnt: if sync_cnt==num_lce_p-1, go to e_ready; else sync_cnt++ and return to e_sync_send.
  - Any other response type is consumed and ignored.
- e_ready:
  - lce_req_ready_o=1 and busy_o=0.
  - On handshake, latch type, addr, src, lru_way, size and data, then go to e_mem_cmd.
- e_mem_cmd:
  - mem_cmd_v_o=1.
  - rd/wr request: block read at the block-aligned address; uc_rd: uc read with the given size; uc_wr: uc write with the latched data.
  - On mem_cmd_ready_i, go to e_mem_resp.
- e_mem_resp:
  - mem_resp_yumi_o = mem_resp_v_i.
  - On consume: latch data, then go to e_lce_cmd.
- e_lce_cmd:
  - lce_cmd_v_o=1, dst=src, way_id=lru_way.
  - rd: data command, state E.
  - wr: data command, state M.
  - uc_rd: uc_data command with the returned data.
  - uc_wr: uc_st_done command, no data.
  - On yumi: cached requests go to e_coh_ack; uc requests go to e_ready.
- e_coh_ack:
  - lce_resp_ready_o=1.
  - On a coh_ack from src, go to e_ready.
  - Other responses are consumed and ignored.
- Output timing:
  - All outputs are driven from registered state and latched fields, with no combinational input→output path except yumi/ready gating inside one state.
  - Valids are held, and payloads are stable, until the handshake completes.
- Ordering and concurrency:
  - Only one request is outstanding; lce_req_ready_o is 0 outside e_ready, so back-pressure is total.
  - Handshakes from different channels can occur in the same cycle only where the FSM permits; none do, since each state owns exactly one channel.
- Minimum latency, req handshake to lce_cmd_v_o: 3 cycles, with mem ready and response immediate.
- Fields: addresses are paddr_width_p wide; block alignment clears the low log2(cce_block_width_p/8) bits; sync_cnt is lce_id_width_p wide.

Test Plan:
- num_lce_p=2, release reset → sync commands to dst 0 then 1, each waiting for its sync_ack; lce_req_ready_o rises only after the ack from LCE 1; busy_o=0.
- rd, addr 0x8000_0044, lru_way 3 → mem block read at 0x8000_0040; data 0xA5..A5 returned → data command, way 3, state E, dst=src; after coh_ack, ready=1.
- uc_wr of 8 bytes 0xDEADBEEF_CAFEF00D at 0x10 → mem uc_wr with that data → uc_st_done command; no coh_ack wait; ready the next cycle.
- Hold mem_cmd_ready_i=0 for 10 cycles and lce_cmd_yumi_i=0 for 5 cycles → valids held, payloads stable, lce_req_ready_o=0 throughout.
- Stray coh_ack arriving during e_sync_ack → consumed, FSM unchanged.
- Assert reset_n_i mid e_mem_resp → all valids are 0 in the same cycle; after release, the sync sequence restarts from LCE 0.

Source files
------------

// File: rtl/bp_cce_lite.sv
// Single-transaction coherence engine: syncs every LCE after reset, then runs one
// request at a time through memory and back to the requesting LCE as a command.
module bp_cce_lite #(
    parameter int paddr_width_p     = 40,
    parameter int lce_id_width_p    = 4,
    parameter int cce_id_width_p    = 4,
    parameter int cce_block_width_p = 512,
    parameter int lce_assoc_p       = 8,
    parameter int num_lce_p         = 1,
    parameter int cce_id_p          = 0,
    localparam int way_w_lp              = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
    localparam int uc_data_w_lp          = 64,
    localparam int lce_req_msg_width_lp  = uc_data_w_lp + 3 + way_w_lp + lce_id_width_p + paddr_width_p + 2,
    localparam int lce_cmd_msg_width_lp  = cce_block_width_p + 2 + way_w_lp + paddr_width_p
                                           + cce_id_width_p + lce_id_width_p + 2,
    localparam int lce_resp_msg_width_lp = lce_id_width_p + 2,
    localparam int mem_msg_width_lp      = cce_block_width_p + 3 + paddr_width_p + 2
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [lce_req_msg_width_lp-1:0]  lce_req_i,
    input  logic                             lce_req_v_i,
    output logic                             lce_req_ready_o,
    output logic [lce_cmd_msg_width_lp-1:0]  lce_cmd_o,
    output logic                             lce_cmd_v_o,
    input  logic                             lce_cmd_yumi_i,
    input  logic [lce_resp_msg_width_lp-1:0] lce_resp_i,
    input  logic                             lce_resp_v_i,
    output logic                             lce_resp_ready_o,
    output logic [mem_msg_width_lp-1:0]      mem_cmd_o,
    output logic                             mem_cmd_v_o,
    input  logic                             mem_cmd_ready_i,
    input  logic [mem_msg_width_lp-1:0]      mem_resp_i,
    input  logic                             mem_resp_v_i,
    output logic                             mem_resp_yumi_o,
    output logic                             busy_o
);

    localparam int offset_w_lp = $clog2(cce_block_width_p / 8);
    localparam logic [2:0] blk_size_lp = 3'(offset_w_lp);
    localparam logic [lce_id_width_p-1:0] last_lce_lp = lce_id_width_p'(num_lce_p - 1);

    typedef enum logic [1:0] {e_req_rd, e_req_wr, e_req_uc_rd, e_req_uc_wr} req_type_e;
    typedef enum logic [1:0] {e_cmd_sync, e_cmd_data, e_cmd_uc_data, e_cmd_uc_st_done} cmd_type_e;
    typedef enum logic [1:0] {e_resp_sync_ack, e_resp_coh_ack} resp_type_e;
    typedef enum logic [1:0] {e_mem_rd, e_mem_uc_rd, e_mem_uc_wr} mem_type_e;
    typedef enum logic [1:0] {e_coh_i, e_coh_s, e_coh_e, e_coh_m} coh_state_e;

    // Message layouts, MSB first; the type field always sits in the two LSBs.
    typedef struct packed {
        logic [uc_data_w_lp-1:0]   data;
        logic [2:0]                size;
        logic [way_w_lp-1:0]       way;
        logic [lce_id_width_p-1:0] src;
        logic [paddr_width_p-1:0]  addr;
        logic [1:0]                msg_type;
    } lce_req_s;

    typedef struct packed {
        logic [cce_block_width_p-1:0] data;
        logic [1:0]                   state;
        logic [way_w_lp-1:0]          way;
        logic [paddr_width_p-1:0]     addr;
        logic [cce_id_width_p-1:0]    src;
        logic [lce_id_width_p-1:0]    dst;
        logic [1:0]                   msg_type;
    } lce_cmd_s;

    typedef struct packed {
        logic [lce_id_width_p-1:0] src;
        logic [1:0]                msg_type;
    } lce_resp_s;

    typedef struct packed {
        logic [cce_block_width_p-1:0] data;
        logic [2:0]                   size;
        logic [paddr_width_p-1:0]     addr;
        logic [1:0]                   msg_type;
    } mem_msg_s;

    typedef enum logic [2:0] {
        e_sync_send, e_sync_ack, e_ready, e_mem_cmd, e_mem_resp, e_lce_cmd, e_coh_ack
    } state_e;

    lce_req_s  req_li;
    lce_resp_s resp_li;
    mem_msg_s  mem_resp_li;
    lce_cmd_s  cmd_lo;
    mem_msg_s  mem_cmd_lo;

    assign req_li      = lce_req_i;
    assign resp_li     = lce_resp_i;
    assign mem_resp_li = mem_resp_i;

    logic unused_mem_resp;
    assign unused_mem_resp = ^{mem_resp_li.size, mem_resp_li.addr, mem_resp_li.msg_type};

    state_e                       state_q, state_d;
    logic [lce_id_width_p-1:0]    sync_cnt_q, sync_cnt_d;
    logic [1:0]                   type_q, type_d;
    logic [paddr_width_p-1:0]     addr_q, addr_d;
    logic [lce_id_width_p-1:0]    src_q, src_d;
    logic [way_w_lp-1:0]          way_q, way_d;
    logic [2:0]                   size_q, size_d;
    logic [cce_block_width_p-1:0] data_q, data_d;

    logic cmd_v, req_ready, resp_ready, mcmd_v, mresp_yumi;
    logic cached;
    logic [paddr_width_p-1:0] blk_addr;

    assign cached   = (type_q == e_req_rd) || (type_q == e_req_wr);
    assign blk_addr = {addr_q[paddr_width_p-1:offset_w_lp], {offset_w_lp{1'b0}}};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= e_sync_send;
            sync_cnt_q <= '0;
            type_q     <= '0;
            addr_q     <= '0;
            src_q      <= '0;
            way_q      <= '0;
            size_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            type_q     <= type_d;
            addr_q     <= addr_d;
            src_q      <= src_d;
            way_q      <= way_d;
            size_q     <= size_d;
            data_q     <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        type_d     = type_q;
        addr_d     = addr_q;
        src_d      = src_q;
        way_d      = way_q;
        size_d     = size_q;
        data_d     = data_q;
        cmd_v      = 1'b0;
        req_ready  = 1'b0;
        resp_ready = 1'b0;
        mcmd_v     = 1'b0;
        mresp_yumi = 1'b0;
        cmd_lo     = '0;
        cmd_lo.src = cce_id_width_p'(cce_id_p);
        mem_cmd_lo = '0;

        case (state_q)
            e_sync_send: begin
                cmd_v           = 1'b1;
                cmd_lo.msg_type = e_cmd_sync;
                cmd_lo.dst      = sync_cnt_q;
                if (lce_cmd_yumi_i) state_d = e_sync_ack;
            end
            e_sync_ack: begin
                resp_ready = 1'b1;
                if (lce_resp_v_i && resp_li.msg_type == e_resp_sync_ack
                    && resp_li.src == sync_cnt_q) begin
                    if (sync_cnt_q == last_lce_lp) begin
                        state_d = e_ready;
                    end else begin
                        sync_cnt_d = sync_cnt_q + 1'b1;
                        state_d    = e_sync_send;
                    end
                end
            end
            e_ready: begin
                req_ready = 1'b1;
                if (lce_req_v_i) begin
                    type_d  = req_li.msg_type;
                    addr_d  = req_li.addr;
                    src_d   = req_li.src;
                    way_d   = req_li.way;
                    size_d  = req_li.size;
                    data_d  = cce_block_width_p'(req_li.data);
                    state_d = e_mem_cmd;
                end
            end
            e_mem_cmd: begin
                mcmd_v = 1'b1;
                if (cached) begin
                    mem_cmd_lo.msg_type = e_mem_rd;
                    mem_cmd_lo.addr     = blk_addr;
                    mem_cmd_lo.size     = blk_size_lp;
                end else if (type_q == e_req_uc_rd) begin
                    mem_cmd_lo.msg_type = e_mem_uc_rd;
                    mem_cmd_lo.addr     = addr_q;
                    mem_cmd_lo.size     = size_q;
                end else begin
                    mem_cmd_lo.msg_type = e_mem_uc_wr;
                    mem_cmd_lo.addr     = addr_q;
                    mem_cmd_lo.size     = size_q;
                    mem_cmd_lo.data     = cce_block_width_p'(data_q[uc_data_w_lp-1:0]);
                end
                if (mem_cmd_ready_i) state_d = e_mem_resp;
            end
            e_mem_resp: begin
                mresp_yumi = mem_resp_v_i;
                if (mem_resp_v_i) begin
                    // Uncached reads return one dword; keep the upper block bits clean.
                    data_d  = cached ? mem_resp_li.data
                                     : cce_block_width_p'(mem_resp_li.data[uc_data_w_lp-1:0]);
                    state_d = e_lce_cmd;
                end
            end
            e_lce_cmd: begin
                cmd_v      = 1'b1;
                cmd_lo.dst = src_q;
                cmd_lo.way = way_q;
                case (type_q)
                    e_req_rd: begin
                        cmd_lo.msg_type = e_cmd_data;
                        cmd_lo.addr     = blk_addr;
                        cmd_lo.state    = e_coh_e;
                        cmd_lo.data     = data_q;
                    end
                    e_req_wr: begin
                        cmd_lo.msg_type = e_cmd_data;
                        cmd_lo.addr     = blk_addr;
                        cmd_lo.state    = e_coh_m;
                        cmd_lo.data     = data_q;
                    end
                    e_req_uc_rd: begin
                        cmd_lo.msg_type = e_cmd_uc_data;
                        cmd_lo.addr     = addr_q;
                        cmd_lo.data     = data_q;
                    end
                    default: begin
                        cmd_lo.msg_type = e_cmd_uc_st_done;
                        cmd_lo.addr     = addr_q;
                    end
                endcase
                if (lce_cmd_yumi_i) state_d = cached ? e_coh_ack : e_ready;
            end
            e_coh_ack: begin
                resp_ready = 1'b1;
                if (lce_resp_v_i && resp_li.msg_type == e_resp_coh_ack && resp_li.src == src_q)
                    state_d = e_ready;
            end
            default: state_d = e_sync_send;
        endcase
    end

    // Reset silences every handshake immediately, even before the state register settles.
    assign lce_cmd_o        = cmd_lo;
    assign mem_cmd_o        = mem_cmd_lo;
    assign lce_cmd_v_o      = cmd_v & reset_n_i;
    assign lce_req_ready_o  = req_ready & reset_n_i;
    assign lce_resp_ready_o = resp_ready & reset_n_i;
    assign mem_cmd_v_o      = mcmd_v & reset_n_i;
    assign mem_resp_yumi_o  = mresp_yumi & reset_n_i;
    assign busy_o           = (state_q != e_ready) | ~reset_n_i;

endmodule

// File: tb/tb_bp_cce_lite.sv
// Randomized bench for bp_cce_lite: an LCE/memory environment drives transactions and
// compares every observed message against a transaction-level reference model.
module tb_bp_cce_lite;

    localparam int PA = 40, LID = 4, CID = 4, BLK = 512, ASSOC = 8, WAYW = 3;
    localparam int NLCE = 2, CCE = 5, BLK_BYTES = BLK / 8;
    localparam int REQ_W  = 64 + 3 + WAYW + LID + PA + 2;
    localparam int CMD_W  = BLK + 2 + WAYW + PA + CID + LID + 2;
    localparam int RESP_W = LID + 2;
    localparam int MEM_W  = BLK + 3 + PA + 2;

    logic              clk = 1'b0;
    logic              reset_n_i;
    logic [REQ_W-1:0]  lce_req_i;
    logic              lce_req_v_i;
    logic              lce_req_ready_o;
    logic [CMD_W-1:0]  lce_cmd_o;
    logic              lce_cmd_v_o;
    logic              lce_cmd_yumi_i;
    logic [RESP_W-1:0] lce_resp_i;
    logic              lce_resp_v_i;
    logic              lce_resp_ready_o;
    logic [MEM_W-1:0]  mem_cmd_o;
    logic              mem_cmd_v_o;
    logic              mem_cmd_ready_i;
    logic [MEM_W-1:0]  mem_resp_i;
    logic              mem_resp_v_i;
    logic              mem_resp_yumi_o;
    logic              busy_o;

    always #5 clk = ~clk;

    bp_cce_lite #(
        .paddr_width_p(PA), .lce_id_width_p(LID), .cce_id_width_p(CID),
        .cce_block_width_p(BLK), .lce_assoc_p(ASSOC), .num_lce_p(NLCE), .cce_id_p(CCE)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .lce_req_i(lce_req_i), .lce_req_v_i(lce_req_v_i), .lce_req_ready_o(lce_req_ready_o),
        .lce_cmd_o(lce_cmd_o), .lce_cmd_v_o(lce_cmd_v_o), .lce_cmd_yumi_i(lce_cmd_yumi_i),
        .lce_resp_i(lce_resp_i), .lce_resp_v_i(lce_resp_v_i), .lce_resp_ready_o(lce_resp_ready_o),
        .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
        .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o),
        .busy_o(busy_o)
    );

    typedef struct packed {
        logic [1:0]     typ;    // 0 rd, 1 wr, 2 uc_rd, 3 uc_wr
        logic [PA-1:0]  addr;
        logic [LID-1:0] src;
        logic [WAYW-1:0] way;
        logic [2:0]     size;
        logic [63:0]    data;
        logic [BLK-1:0] mdata;
        logic [3:0]     mc_dly;
        logic [3:0]     mr_dly;
        logic [3:0]     y_dly;
    } txn_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REQ_W-1:0] pk_req(input txn_t t);
        return {t.data, t.size, t.way, t.src, t.addr, t.typ};
    endfunction

    function automatic logic [CMD_W-1:0] pk_cmd(input logic [1:0] typ, input logic [LID-1:0] dst,
            input logic [PA-1:0] a, input logic [WAYW-1:0] w, input logic [1:0] st,
            input logic [BLK-1:0] d);
        return {d, st, w, a, CID'(CCE), dst, typ};
    endfunction

    function automatic logic [MEM_W-1:0] pk_mem(input logic [1:0] typ, input logic [PA-1:0] a,
            input logic [2:0] sz, input logic [BLK-1:0] d);
        return {d, sz, a, typ};
    endfunction

    function automatic logic [RESP_W-1:0] pk_resp(input logic [1:0] typ, input logic [LID-1:0] s);
        return {s, typ};
    endfunction

    // Reference model: what memory should be asked, and what the LCE should be told.
    function automatic logic [MEM_W-1:0] model_mem_cmd(input txn_t t);
        logic [PA-1:0] blk;
        blk = t.addr - (t.addr % BLK_BYTES);
        case (t.typ)
            2'd0, 2'd1: return pk_mem(2'd0, blk, 3'($clog2(BLK_BYTES)), '0);
            2'd2:       return pk_mem(2'd1, t.addr, t.size, '0);
            default:    return pk_mem(2'd2, t.addr, t.size, BLK'(t.data));
        endcase
    endfunction

    function automatic logic [CMD_W-1:0] model_lce_cmd(input txn_t t);
        logic [PA-1:0] blk;
        blk = t.addr - (t.addr % BLK_BYTES);
        case (t.typ)
            2'd0:    return pk_cmd(2'd1, t.src, blk, t.way, 2'd2, t.mdata);
            2'd1:    return pk_cmd(2'd1, t.src, blk, t.way, 2'd3, t.mdata);
            2'd2:    return pk_cmd(2'd2, t.src, t.addr, t.way, 2'd0, BLK'(t.mdata[63:0]));
            default: return pk_cmd(2'd3, t.src, t.addr, t.way, 2'd0, '0);
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_sync(input bit stray);
        for (int i = 0; i < NLCE; i++) begin
            chk("sync_v", lce_cmd_v_o, 1'b1);
            chk("sync_cmd", lce_cmd_o, pk_cmd(2'd0, LID'(i), '0, '0, 2'd0, '0));
            chk("sync_busy", busy_o, 1'b1);
            chk("sync_req_rdy", lce_req_ready_o, 1'b0);
            chk("sync_resp_rdy_early", lce_resp_ready_o, 1'b0);
            lce_cmd_yumi_i = 1'b1;
            cyc();
            lce_cmd_yumi_i = 1'b0;
            chk("sync_ack_rdy", lce_resp_ready_o, 1'b1);
            chk("sync_v_off", lce_cmd_v_o, 1'b0);
            if (stray) begin
                lce_resp_i   = pk_resp(2'd1, LID'(i));
                lce_resp_v_i = 1'b1;
                cyc();
                lce_resp_i   = pk_resp(2'd0, LID'(i + 1));
                chk("stray_coh_rdy", lce_resp_ready_o, 1'b1);
                chk("stray_coh_cmd_v", lce_cmd_v_o, 1'b0);
                cyc();
                lce_resp_v_i = 1'b0;
                chk("stray_src_rdy", lce_resp_ready_o, 1'b1);
                chk("stray_src_req_rdy", lce_req_ready_o, 1'b0);
            end
            lce_resp_i   = pk_resp(2'd0, LID'(i));
            lce_resp_v_i = 1'b1;
            cyc();
            lce_resp_v_i = 1'b0;
        end
        chk("synced_req_rdy", lce_req_ready_o, 1'b1);
        chk("synced_busy", busy_o, 1'b0);
        chk("synced_cmd_v", lce_cmd_v_o, 1'b0);
    endtask

    task automatic run_txn(input txn_t t);
        bit cached;
        cached = (t.typ < 2);
        chk("idle_req_rdy", lce_req_ready_o, 1'b1);
        chk("idle_busy", busy_o, 1'b0);
        lce_req_i   = pk_req(t);
        lce_req_v_i = 1'b1;
        cyc();
        lce_req_v_i = 1'b0;
        lce_req_i   = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i <= int'(t.mc_dly); i++) begin
            chk("mem_cmd_v", mem_cmd_v_o, 1'b1);
            chk("mem_cmd", mem_cmd_o, model_mem_cmd(t));
            chk("mem_req_rdy", lce_req_ready_o, 1'b0);
            if (i == int'(t.mc_dly)) mem_cmd_ready_i = 1'b1;
            cyc();
        end
        mem_cmd_ready_i = 1'b0;
        chk("mem_cmd_v_off", mem_cmd_v_o, 1'b0);
        for (int i = 0; i <= int'(t.mr_dly); i++) begin
            if (i == int'(t.mr_dly)) begin
                mem_resp_i   = pk_mem(2'd0, t.addr, 3'd6, t.mdata);
                mem_resp_v_i = 1'b1;
            end
            #1;
            chk("mem_yumi", mem_resp_yumi_o, (i == int'(t.mr_dly)));
            chk("cmd_v_early", lce_cmd_v_o, 1'b0);
            cyc();
        end
        mem_resp_v_i = 1'b0;
        for (int i = 0; i <= int'(t.y_dly); i++) begin
            chk("lce_cmd_v", lce_cmd_v_o, 1'b1);
            chk("lce_cmd", lce_cmd_o, model_lce_cmd(t));
            chk("cmd_req_rdy", lce_req_ready_o, 1'b0);
            if (i == int'(t.y_dly)) lce_cmd_yumi_i = 1'b1;
            cyc();
        end
        lce_cmd_yumi_i = 1'b0;
        if (cached) begin
            chk("coh_resp_rdy", lce_resp_ready_o, 1'b1);
            chk("coh_req_rdy", lce_req_ready_o, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                lce_resp_i   = pk_resp(2'd1, t.src ^ LID'(1));
                lce_resp_v_i = 1'b1;
                cyc();
                lce_resp_v_i = 1'b0;
                chk("coh_wrong_src_rdy", lce_req_ready_o, 1'b0);
                chk("coh_wrong_src_resp", lce_resp_ready_o, 1'b1);
            end
            lce_resp_i   = pk_resp(2'd1, t.src);
            lce_resp_v_i = 1'b1;
            cyc();
            lce_resp_v_i = 1'b0;
        end
        chk("done_req_rdy", lce_req_ready_o, 1'b1);
        chk("done_busy", busy_o, 1'b0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_cmd_v"}, lce_cmd_v_o, 1'b0);
        chk({tag, "_mem_v"}, mem_cmd_v_o, 1'b0);
        chk({tag, "_yumi"}, mem_resp_yumi_o, 1'b0);
        chk({tag, "_req_rdy"}, lce_req_ready_o, 1'b0);
        chk({tag, "_resp_rdy"}, lce_resp_ready_o, 1'b0);
        chk({tag, "_busy"}, busy_o, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        txn_t t;
        reset_n_i       = 1'b0;
        lce_req_i       = '0;
        lce_req_v_i     = 1'b0;
        lce_cmd_yumi_i  = 1'b0;
        lce_resp_i      = '0;
        lce_resp_v_i    = 1'b0;
        mem_cmd_ready_i = 1'b0;
        mem_resp_i      = '0;
        mem_resp_v_i    = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        reset_n_i = 1'b1;
        #1;
        run_sync(1'b1);

        t        = '0;
        t.typ    = 2'd0;
        t.addr   = PA'(40'h80_0000_44);
        t.addr   = PA'(64'h8000_0044);
        t.src    = LID'(1);
        t.way    = WAYW'(3);
        t.mdata  = {64{8'hA5}};
        run_txn(t);

        t        = '0;
        t.typ    = 2'd3;
        t.addr   = PA'(64'h10);
        t.size   = 3'd3;
        t.data   = 64'hDEADBEEF_CAFEF00D;
        t.src    = LID'(0);
        run_txn(t);

        t        = '0;
        t.typ    = 2'd1;
        t.addr   = PA'(64'h1234_5678);
        t.way    = WAYW'(5);
        t.mdata  = {16{32'h0F1E_2D3C}};
        t.mc_dly = 4'd10;
        t.y_dly  = 4'd5;
        run_txn(t);

        for (int n = 0; n < 24; n++) begin
            t.typ    = 2'($urandom_range(0, 3));
            t.addr   = PA'({$urandom, $urandom});
            t.src    = LID'($urandom_range(0, 15));
            t.way    = WAYW'($urandom_range(0, ASSOC - 1));
            t.size   = 3'($urandom_range(0, 3));
            t.data   = {$urandom, $urandom};
            for (int w = 0; w < BLK / 32; w++) t.mdata[w*32 +: 32] = $urandom;
            t.mc_dly = 4'($urandom_range(0, 3));
            t.mr_dly = 4'($urandom_range(0, 3));
            t.y_dly  = 4'($urandom_range(0, 3));
            run_txn(t);
        end

        // Reset while waiting on the memory response: everything must go quiet at once.
        t        = '0;
        t.typ    = 2'd0;
        t.addr   = PA'(64'h4000);
        lce_req_i   = pk_req(t);
        lce_req_v_i = 1'b1;
        cyc();
        lce_req_v_i     = 1'b0;
        mem_cmd_ready_i = 1'b1;
        cyc();
        mem_cmd_ready_i = 1'b0;
        mem_resp_i      = pk_mem(2'd0, t.addr, 3'd6, {16{32'h5555_AAAA}});
        mem_resp_v_i    = 1'b1;
        #1;
        chk("pre_reset_yumi", mem_resp_yumi_o, 1'b1);
        reset_n_i = 1'b0;
        #1;
        check_quiet("midreset");
        cyc();
        check_quiet("midreset_hold");
        mem_resp_v_i = 1'b0;
        reset_n_i    = 1'b1;
        #1;
        run_sync(1'b0);

        t        = '0;
        t.typ    = 2'd2;
        t.addr   = PA'(64'h88);
        t.size   = 3'd2;
        t.src    = LID'(1);
        t.mdata  = {16{32'h1357_9BDF}};
        run_txn(t);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
